// File: rtl/debug_ocimem_arbiter_if.sv
// Bus bundle for the debug OCI-memory arbiter: JTAG action strobes and
// monitor results, the Avalon debug-slave port, and the debug RAM port.
//
// Handshake rules:
//  - Avalon: a request (av_read or av_write) is held stable while
//    av_waitrequest=1. It completes on the first clock edge that sees
//    av_waitrequest=0. av_readdata is valid in that cycle.
//  - JTAG: jtag_access is a one-cycle strobe. It is accepted only while
//    jtag_busy=0. mon_ready rises when the accepted access has finished.
interface debug_ocimem_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   logic              jtag_set_addr;
   logic [ADDR_W-1:0] jtag_addr_in;
   logic              jtag_access;
   logic              jtag_wr;
   logic [DATA_W-1:0] jtag_wdata;
   logic              jtag_busy;
   logic [DATA_W-1:0] mon_dreg;
   logic              mon_ready;

   logic [ADDR_W-1:0] av_address;
   logic              av_read;
   logic              av_write;
   logic [DATA_W-1:0] av_writedata;
   logic [BE_W-1:0]   av_byteenable;
   logic [DATA_W-1:0] av_readdata;
   logic              av_waitrequest;

   logic [ADDR_W-1:0] ram_addr;
   logic              ram_wren;
   logic [BE_W-1:0]   ram_byteenable;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   // Arbiter view
   modport slave (
      input  jtag_set_addr, jtag_addr_in, jtag_access, jtag_wr, jtag_wdata,
      output jtag_busy, mon_dreg, mon_ready,
      input  av_address, av_read, av_write, av_writedata, av_byteenable,
      output av_readdata, av_waitrequest,
      output ram_addr, ram_wren, ram_byteenable, ram_wdata,
      input  ram_rdata
   );

   // Environment view (requesters and RAM)
   modport master (
      output jtag_set_addr, jtag_addr_in, jtag_access, jtag_wr, jtag_wdata,
      input  jtag_busy, mon_dreg, mon_ready,
      output av_address, av_read, av_write, av_writedata, av_byteenable,
      input  av_readdata, av_waitrequest,
      input  ram_addr, ram_wren, ram_byteenable, ram_wdata,
      output ram_rdata
   );
endinterface

// File: rtl/debug_ocimem_arbiter.sv
// Shares the single-port debug RAM between the Avalon debug-slave port and
// the JTAG OCI-memory actions. Round-robin on ties, holds the JTAG
// (auto-incrementing) address and returns JTAG read data to mon_dreg.
module debug_ocimem_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int AUTO_INC = 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   debug_ocimem_arbiter_if.slave  bus,
   output logic [1:0]             o_dbg_state
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_AV_RD = 2'd1,
      S_JT_RD = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic              r_last_grant;   // 1: JTAG was granted last, 0: Avalon
   logic              r_jtag_pend;
   logic              r_jtag_wr;
   logic [DATA_W-1:0] r_jtag_wdata;
   logic [ADDR_W-1:0] r_jtag_addr;
   logic [DATA_W-1:0] r_mon_dreg;
   logic              r_mon_ready;

   logic w_av_req;
   logic w_in_idle;
   logic w_grant_av;
   logic w_grant_jt;
   logic w_jtag_busy;
   logic w_jtag_accept;

   assign w_av_req      = bus.av_read | bus.av_write;
   assign w_in_idle     = (r_state == S_IDLE);
   // On a tie the side that did not win last time is granted
   assign w_grant_av    = w_in_idle & w_av_req & (~r_jtag_pend | r_last_grant);
   assign w_grant_jt    = w_in_idle & r_jtag_pend & (~w_av_req | ~r_last_grant);
   assign w_jtag_busy   = r_jtag_pend | (r_state == S_JT_RD);
   assign w_jtag_accept = bus.jtag_access & ~w_jtag_busy;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next_state;
   end

   // Next state: reads take one extra cycle for the RAM latency; writes stay in IDLE
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_grant_av && !bus.av_write)    w_next_state = S_AV_RD;
            else if (w_grant_jt && !r_jtag_wr)  w_next_state = S_JT_RD;
            else                                w_next_state = S_IDLE;
         end
         S_AV_RD: w_next_state = S_IDLE;
         S_JT_RD: w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Outputs: RAM port mux and Avalon stall; nothing reaches the RAM during reset
   always_comb begin
      bus.ram_addr       = bus.av_address;
      bus.ram_wdata      = bus.av_writedata;
      bus.ram_byteenable = bus.av_byteenable;
      bus.ram_wren       = 1'b0;
      bus.av_waitrequest = 1'b1;
      if (reset_n) begin
         if (w_grant_jt) begin
            bus.ram_addr       = r_jtag_addr;
            bus.ram_wdata      = r_jtag_wdata;
            bus.ram_byteenable = '1;
            bus.ram_wren       = r_jtag_wr;
         end else if (w_grant_av) begin
            bus.ram_wren       = bus.av_write;
            bus.av_waitrequest = ~bus.av_write;
         end
         if (r_state == S_AV_RD) bus.av_waitrequest = 1'b0;
      end
   end

   // Round-robin memory of the last winner
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)        r_last_grant <= 1'b1;
      else if (w_grant_av) r_last_grant <= 1'b0;
      else if (w_grant_jt) r_last_grant <= 1'b1;
   end

   // JTAG request capture; strobes arriving while busy are dropped
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_jtag_pend  <= 1'b0;
         r_jtag_wr    <= 1'b0;
         r_jtag_wdata <= '0;
      end else if (w_grant_jt) begin
         r_jtag_pend  <= 1'b0;
      end else if (w_jtag_accept) begin
         r_jtag_pend  <= 1'b1;
         r_jtag_wr    <= bus.jtag_wr;
         r_jtag_wdata <= bus.jtag_wdata;
      end
   end

   // JTAG address: an explicit load beats the post-grant increment
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                           r_jtag_addr <= '0;
      else if (bus.jtag_set_addr)             r_jtag_addr <= bus.jtag_addr_in;
      else if (w_grant_jt && (AUTO_INC != 0)) r_jtag_addr <= r_jtag_addr + 1'b1;
   end

   // Monitor result: read data captured in JT_RD, ready cleared by a new access
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mon_dreg  <= '0;
         r_mon_ready <= 1'b0;
      end else if (r_state == S_JT_RD) begin
         r_mon_dreg  <= bus.ram_rdata;
         r_mon_ready <= 1'b1;
      end else if (w_grant_jt && r_jtag_wr) begin
         r_mon_ready <= 1'b1;
      end else if (w_jtag_accept) begin
         r_mon_ready <= 1'b0;
      end
   end

   assign bus.av_readdata = bus.ram_rdata;
   assign bus.jtag_busy   = w_jtag_busy;
   assign bus.mon_dreg    = r_mon_dreg;
   assign bus.mon_ready   = r_mon_ready;
   assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_debug_ocimem_arbiter.sv
// Bench for debug_ocimem_arbiter: a debug RAM model, Avalon and JTAG driver
// tasks, a memory-image reference model and a queue-based scoreboard.
module tb_debug_ocimem_arbiter;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   debug_ocimem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) u_if ();
   debug_ocimem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) u_if2 ();
   logic [1:0] dbg_state;
   logic [1:0] dbg_state2;

   debug_ocimem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .AUTO_INC(1)) u_dut (
      .clk(clk), .reset_n(reset_n), .bus(u_if), .o_dbg_state(dbg_state));
   debug_ocimem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .AUTO_INC(0)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .bus(u_if2), .o_dbg_state(dbg_state2));

   // Second instance (no auto-increment) sees the same JTAG strobes, no Avalon
   assign u_if2.jtag_set_addr = u_if.jtag_set_addr;
   assign u_if2.jtag_addr_in  = u_if.jtag_addr_in;
   assign u_if2.jtag_access   = u_if.jtag_access;
   assign u_if2.jtag_wr       = u_if.jtag_wr;
   assign u_if2.jtag_wdata    = u_if.jtag_wdata;
   assign u_if2.av_address    = '0;
   assign u_if2.av_read       = 1'b0;
   assign u_if2.av_write      = 1'b0;
   assign u_if2.av_writedata  = '0;
   assign u_if2.av_byteenable = '0;

   // ---------------- debug RAM models (1-cycle read latency) ----------------
   logic [DW-1:0] ram1 [256];
   logic [DW-1:0] ram2 [256];

   always @(posedge clk) begin
      if (u_if.ram_wren)
         for (int b = 0; b < BW; b++)
            if (u_if.ram_byteenable[b]) ram1[u_if.ram_addr][8*b +: 8] <= u_if.ram_wdata[8*b +: 8];
      u_if.ram_rdata <= ram1[u_if.ram_addr];
   end

   always @(posedge clk) begin
      if (u_if2.ram_wren)
         for (int b = 0; b < BW; b++)
            if (u_if2.ram_byteenable[b]) ram2[u_if2.ram_addr][8*b +: 8] <= u_if2.ram_wdata[8*b +: 8];
      u_if2.ram_rdata <= ram2[u_if2.ram_addr];
   end

   // ---------------- reference model and scoreboard ----------------
   logic [DW-1:0] ref_mem [256];
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_last_rd;
   logic [DW-1:0] av_exp_q [$];
   logic [DW-1:0] jt_exp_q [$];

   int n_tests = 0;
   int n_fail  = 0;
   int av_done = 0;
   int wr1_cnt = 0;
   logic [AW-1:0] last2_waddr;
   logic prev_ready = 1'b0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got timeout/empty expected event", name);
   endtask

   // A JTAG access as the host sees it: optional address load, one memory
   // operation, then the address moves on by one (8-bit wrap)
   function automatic void model_jt(input bit wr, input logic [DW-1:0] d,
                                    input bit set, input logic [AW-1:0] a);
      if (set) m_addr = a;
      if (wr) ref_mem[m_addr] = d;
      else    m_last_rd = ref_mem[m_addr];
      jt_exp_q.push_back(m_last_rd);
      m_addr = m_addr + 1'b1;
   endfunction

   // Monitor: compares whatever the DUT presents against the queued expectations
   always @(negedge clk) begin
      if (reset_n) begin
         if (u_if.av_read && !u_if.av_waitrequest) begin
            av_done++;
            if (av_exp_q.size() == 0) fail_now("av_rdata_unexpected");
            else check("av_rdata", u_if.av_readdata, av_exp_q.pop_front());
         end
         if (u_if.mon_ready && !prev_ready) begin
            if (jt_exp_q.size() == 0) fail_now("mon_dreg_unexpected");
            else check("mon_dreg", u_if.mon_dreg, jt_exp_q.pop_front());
         end
         if (u_if.ram_wren) wr1_cnt++;
         if (u_if2.ram_wren) last2_waddr = u_if2.ram_addr;
      end
      prev_ready = u_if.mon_ready;
   end

   // ---------------- driver tasks (entered just after a rising edge) ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic av_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [BW-1:0] be, output int waits);
      for (int b = 0; b < BW; b++)
         if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      u_if.av_address = a;
      u_if.av_writedata = d;
      u_if.av_byteenable = be;
      u_if.av_write = 1'b1;
      waits = 0;
      forever begin
         @(negedge clk);
         if (!u_if.av_waitrequest) break;
         waits++;
         if (waits > 50) begin fail_now("av_wr_timeout"); break; end
      end
      check("av_wr_wren", {31'd0, u_if.ram_wren}, 32'd1);
      check("av_wr_addr", {24'd0, u_if.ram_addr}, {24'd0, a});
      tick();
      u_if.av_write = 1'b0;
   endtask

   task automatic av_rd(input logic [AW-1:0] a, output int waits);
      av_exp_q.push_back(ref_mem[a]);
      u_if.av_address = a;
      u_if.av_read = 1'b1;
      waits = 0;
      forever begin
         @(negedge clk);
         if (!u_if.av_waitrequest) break;
         waits++;
         if (waits > 50) begin fail_now("av_rd_timeout"); break; end
      end
      tick();
      u_if.av_read = 1'b0;
   endtask

   task automatic jt_wait_done();
      int cyc = 0;
      @(negedge clk);
      while (u_if.jtag_busy || !u_if.mon_ready) begin
         @(negedge clk);
         cyc++;
         if (cyc > 50) begin fail_now("jt_timeout"); break; end
      end
      tick();
   endtask

   task automatic jt_access(input bit wr, input logic [DW-1:0] d,
                            input bit set, input logic [AW-1:0] a);
      model_jt(wr, d, set, a);
      u_if.jtag_wr = wr;
      u_if.jtag_wdata = d;
      u_if.jtag_set_addr = set;
      u_if.jtag_addr_in = a;
      u_if.jtag_access = 1'b1;
      tick();
      u_if.jtag_access = 1'b0;
      u_if.jtag_set_addr = 1'b0;
      @(negedge clk);
      check("jt_ready_fall", {31'd0, u_if.mon_ready}, 32'd0);
      jt_wait_done();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int w;
      int c0;
      int w0;
      logic [DW-1:0] v;
      for (int i = 0; i < 256; i++) begin
         v = $urandom;
         ram1[i] = v;
         ref_mem[i] = v;
         ram2[i] = $urandom;
      end
      m_addr = '0;
      m_last_rd = '0;
      u_if.jtag_set_addr = 1'b0; u_if.jtag_addr_in = '0; u_if.jtag_access = 1'b0;
      u_if.jtag_wr = 1'b0; u_if.jtag_wdata = '0;
      u_if.av_address = 8'h33; u_if.av_read = 1'b0; u_if.av_write = 1'b1;
      u_if.av_writedata = 32'hFFFF_FFFF; u_if.av_byteenable = '1;

      // Reset, with an Avalon write held that must not reach the RAM
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_waitreq", {31'd0, u_if.av_waitrequest}, 32'd1);
      check("rst_wren", {31'd0, u_if.ram_wren}, 32'd0);
      check("rst_busy", {31'd0, u_if.jtag_busy}, 32'd0);
      check("rst_mon_ready", {31'd0, u_if.mon_ready}, 32'd0);
      check("rst_mon_dreg", u_if.mon_dreg, 32'd0);
      check("rst_state", {30'd0, dbg_state}, 32'd0);
      u_if.av_write = 1'b0;
      reset_n = 1'b1;
      tick();

      // 1: Avalon write then read, plus back-to-back writes
      av_wr(8'h05, 32'hDEADBEEF, 4'hF, w);
      check("t1_wr_waits", w, 0);
      av_rd(8'h05, w);
      check("t1_rd_waits", w, 1);
      for (int i = 0; i < 4; i++) begin
         av_wr(8'h40 + i[7:0], $urandom, 4'(($urandom_range(0, 15))), w);
         check("t1_b2b_waits", w, 0);
      end
      for (int i = 0; i < 4; i++) begin
         av_rd(8'h40 + i[7:0], w);
         check("t1_b2b_rd_waits", w, 1);
      end

      // 2: JTAG write then auto-incremented read
      jt_access(1'b1, 32'h12345678, 1'b1, 8'h10);
      check("t2_ram10", ram1[8'h10], 32'h12345678);
      jt_access(1'b0, 32'h0, 1'b0, 8'h00);

      // 3: continuous Avalon reads with JTAG reads interleaved
      fork
         begin
            int aw;
            for (int i = 0; i < 12; i++) begin
               av_rd(8'($urandom_range(0, 127)), aw);
               check("t3_rd_waits_le3", {31'd0, aw <= 3}, 32'd1);
            end
         end
         begin
            tick(); tick();
            c0 = av_done;
            jt_access(1'b0, 32'h0, 1'b1, 8'h90);
            check("t3_av_grants_le1", {31'd0, (av_done - c0) <= 1}, 32'd1);
            c0 = av_done;
            jt_access(1'b0, 32'h0, 1'b0, 8'h00);
            check("t3_av_grants_le1b", {31'd0, (av_done - c0) <= 1}, 32'd1);
         end
      join

      // 4: address wrap (auto-inc) versus held address (no auto-inc)
      jt_access(1'b1, 32'hA1A1_0001, 1'b1, 8'hFF);
      check("t4_ai0_waddr1", {24'd0, last2_waddr}, 32'h0000_00FF);
      jt_access(1'b1, 32'hB2B2_0002, 1'b0, 8'h00);
      check("t4_ai0_waddr2", {24'd0, last2_waddr}, 32'h0000_00FF);
      check("t4_ram00", ram1[8'h00], 32'hB2B2_0002);
      jt_access(1'b0, 32'h0, 1'b0, 8'h00);
      check("t4_ai0_dreg", u_if2.mon_dreg, 32'hB2B2_0002);

      // 5: a second strobe while busy is ignored
      model_jt(1'b0, 32'h0, 1'b1, 8'h20);
      u_if.jtag_wr = 1'b0; u_if.jtag_set_addr = 1'b1; u_if.jtag_addr_in = 8'h20;
      u_if.jtag_access = 1'b1;
      tick();
      u_if.jtag_set_addr = 1'b0;
      u_if.jtag_wr = 1'b1; u_if.jtag_wdata = 32'hA5A5A5A5;
      w0 = wr1_cnt;
      tick();
      u_if.jtag_access = 1'b0;
      jt_wait_done();
      tick(); tick(); tick();
      check("t5_no_extra_write", wr1_cnt - w0, 0);
      check("t5_idle_busy", {31'd0, u_if.jtag_busy}, 32'd0);
      jt_access(1'b0, 32'h0, 1'b0, 8'h00);

      // 6a: reset during AV_RD
      u_if.av_address = 8'h07; u_if.av_read = 1'b1;
      tick();
      check("t6_pre_av_rd", {30'd0, dbg_state}, 32'd1);
      reset_n = 1'b0;
      @(negedge clk);
      check("t6a_state", {30'd0, dbg_state}, 32'd0);
      check("t6a_waitreq", {31'd0, u_if.av_waitrequest}, 32'd1);
      check("t6a_busy", {31'd0, u_if.jtag_busy}, 32'd0);
      u_if.av_read = 1'b0;
      reset_n = 1'b1;
      m_addr = '0; m_last_rd = '0;
      tick();

      // 6b: reset during JT_RD, Avalon write held throughout the reset
      u_if.jtag_wr = 1'b0; u_if.jtag_access = 1'b1;
      tick();
      u_if.jtag_access = 1'b0;
      tick();
      check("t6_pre_jt_rd", {30'd0, dbg_state}, 32'd2);
      u_if.av_address = 8'h08; u_if.av_writedata = 32'h0BAD_0BAD;
      u_if.av_byteenable = '1; u_if.av_write = 1'b1;
      reset_n = 1'b0;
      w0 = wr1_cnt;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t6b_state", {30'd0, dbg_state}, 32'd0);
         check("t6b_busy", {31'd0, u_if.jtag_busy}, 32'd0);
         check("t6b_wren", {31'd0, u_if.ram_wren}, 32'd0);
         check("t6b_waitreq", {31'd0, u_if.av_waitrequest}, 32'd1);
      end
      check("t6b_ram08", ram1[8'h08], ref_mem[8'h08]);
      u_if.av_write = 1'b0;
      reset_n = 1'b1;
      m_addr = '0; m_last_rd = '0;
      tick();
      jt_access(1'b0, 32'h0, 1'b0, 8'h00);

      // Random concurrent traffic: Avalon in 0x00-0x7F, JTAG in 0x80-0xFF
      fork
         begin
            int aw;
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 2)) tick();
               if ($urandom_range(0, 1) == 1) begin
                  av_wr(8'($urandom_range(0, 127)), $urandom, 4'($urandom_range(0, 15)), aw);
                  check("rnd_wr_waits_le2", {31'd0, aw <= 2}, 32'd1);
               end else begin
                  av_rd(8'($urandom_range(0, 127)), aw);
                  check("rnd_rd_waits_le3", {31'd0, aw <= 3}, 32'd1);
               end
            end
         end
         begin
            bit set;
            for (int i = 0; i < 25; i++) begin
               repeat ($urandom_range(0, 3)) tick();
               set = ($urandom_range(0, 1) == 1) || (m_addr < 8'h80) || (m_addr >= 8'hF0);
               jt_access(1'($urandom_range(0, 1)), $urandom, set, 8'h80 + 8'($urandom_range(0, 63)));
            end
         end
      join

      repeat (4) tick();
      w0 = 0;
      for (int i = 0; i < 256; i++)
         if (ram1[i] !== ref_mem[i]) w0++;
      check("ram_image_mismatches", w0, 0);
      check("av_queue_empty", av_exp_q.size(), 0);
      check("jt_queue_empty", jt_exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
